// File: rtl/ldpc_iter_ctrl.sv
// ---------------------------------------------------------------------------
// ldpc_iter_ctrl
//
// Iteration scheduler for the 10-bit LDPC decoder datapath (VarToCheck,
// CheckToVar and Belief nodes). A start request loads the channel evidence.
// The block then cycles the datapath through the V2C, C2V and BELIEF phases.
// After each iteration it inspects the parity result in a CHECK state. The
// decode ends on a zero syndrome or when the programmable iteration limit is
// reached, and the result is offered on an out_valid/out_ready handshake.
//
// Ports
//   i_clk          : clock, all logic on the rising edge
//   i_rst_n        : synchronous active-low reset
//   i_start        : decode request, accepted when i_start && o_in_ready
//   o_in_ready     : high only while idle
//   i_max_iter     : iteration limit, sampled on acceptance (0 acts as 1)
//   i_abort        : cancels an active decode (ignored in IDLE and DONE)
//   i_syndrome_ok  : datapath parity result, valid in the cycle after belief
//   o_load_en      : datapath load-evidence / clear-messages strobe
//   o_v2c_en       : variable-to-check update strobe
//   o_c2v_en       : check-to-variable update strobe
//   o_belief_en    : belief update / corrected_seq register strobe
//   o_busy         : high in every state except IDLE
//   o_out_valid    : result available (DONE)
//   i_out_ready    : consumer accepts the result
//   o_iter_count   : completed iterations, stable while o_out_valid is high
//   o_converged    : decode ended on a satisfied syndrome
//
// Every output is either a register or decoded only from the state register.
// No input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ldpc_iter_ctrl #(
    parameter int ITER_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_in_ready,
    input  logic [ITER_W-1:0] i_max_iter,
    input  logic              i_abort,
    input  logic              i_syndrome_ok,
    output logic              o_load_en,
    output logic              o_v2c_en,
    output logic              o_c2v_en,
    output logic              o_belief_en,
    output logic              o_busy,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ITER_W-1:0] o_iter_count,
    output logic              o_converged
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_V2C    = 3'd2,
        S_C2V    = 3'd3,
        S_BELIEF = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [ITER_W-1:0] ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ITER_W-1:0] r_limit;
    logic [ITER_W-1:0] r_iter;
    logic              r_conv;

    logic              w_accept;
    logic              w_active;
    logic              w_limit_hit;
    logic [ITER_W-1:0] w_limit_ld;

    // A start is accepted only in IDLE. Requests made while busy are dropped.
    assign w_accept    = (r_state == S_IDLE) && i_start;

    // Abort is honoured only in the states that drive the datapath or wait
    // on it. The finished result in DONE cannot be cancelled.
    assign w_active    = (r_state == S_LOAD) || (r_state == S_V2C) ||
                         (r_state == S_C2V)  || (r_state == S_BELIEF) ||
                         (r_state == S_CHECK);

    // In CHECK, r_iter already includes the iteration that just finished.
    assign w_limit_hit = (r_iter == r_limit);

    // A zero limit would never terminate, so it is promoted to one.
    assign w_limit_ld  = (i_max_iter == '0) ? ONE : i_max_iter;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b1;
        o_load_en   = 1'b0;
        o_v2c_en    = 1'b0;
        o_c2v_en    = 1'b0;
        o_belief_en = 1'b0;
        o_out_valid = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                o_load_en   = 1'b1;
                w_state_nxt = i_abort ? S_IDLE : S_V2C;
            end

            S_V2C: begin
                o_v2c_en    = 1'b1;
                w_state_nxt = i_abort ? S_IDLE : S_C2V;
            end

            S_C2V: begin
                o_c2v_en    = 1'b1;
                w_state_nxt = i_abort ? S_IDLE : S_BELIEF;
            end

            S_BELIEF: begin
                o_belief_en = 1'b1;
                w_state_nxt = i_abort ? S_IDLE : S_CHECK;
            end

            S_CHECK: begin
                // Abort wins over the convergence / limit decision. Another
                // iteration goes back to V2C, not LOAD, so the datapath
                // keeps its messages between iterations.
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_syndrome_ok || w_limit_hit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_V2C;
                end
            end

            S_DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Limit, iteration counter and converged flag
    //
    // All three change only on acceptance, at the end of BELIEF, or in
    // CHECK. An aborted run therefore leaves the values from its last
    // completed step. After DONE they hold until the next acceptance.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_limit <= ONE;
            r_iter  <= '0;
            r_conv  <= 1'b0;
        end else if (w_accept) begin
            r_limit <= w_limit_ld;
            r_iter  <= '0;
            r_conv  <= 1'b0;
        end else if (w_active && !i_abort) begin
            // r_iter is bounded by r_limit, so this increment never wraps.
            if (r_state == S_BELIEF) begin
                r_iter <= r_iter + ONE;
            end
            if ((r_state == S_CHECK) && i_syndrome_ok) begin
                r_conv <= 1'b1;
            end
        end
    end

    assign o_iter_count = r_iter;
    assign o_converged  = r_conv;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ldpc_iter_ctrl
//
// Self-checking bench for ldpc_iter_ctrl. Each decode is described by its
// limit, the iteration at which the syndrome first passes, an optional abort
// or reset cycle, and the out_ready delay. The reference model works out the
// run length and the final result from those values. It then gives the
// expected outputs of every cycle as a function of the cycle number counted
// from the acceptance edge. The bench sets unrelated inputs (start while
// busy, syndrome outside CHECK, abort/start in DONE, max_iter after
// acceptance) to random values.
// ---------------------------------------------------------------------------
module tb_ldpc_iter_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         syn = 1'b0;
    logic         ordy = 1'b0;
    logic [W-1:0] mi = '0;

    logic         in_ready, load_en, v2c_en, c2v_en, belief_en, busy, out_valid, conv;
    logic [W-1:0] iter;

    int n_chk  = 0;
    int n_fail = 0;

    ldpc_iter_ctrl #(.ITER_W(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .o_in_ready    (in_ready),
        .i_max_iter    (mi),
        .i_abort       (abort),
        .i_syndrome_ok (syn),
        .o_load_en     (load_en),
        .o_v2c_en      (v2c_en),
        .o_c2v_en      (c2v_en),
        .o_belief_en   (belief_en),
        .o_busy        (busy),
        .o_out_valid   (out_valid),
        .i_out_ready   (ordy),
        .o_iter_count  (iter),
        .o_converged   (conv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {in_ready, busy, load, v2c, c2v, belief, out_valid}
    function automatic logic [31:0] ctrl_obs();
        return {25'd0, in_ready, busy, load_en, v2c_en, c2v_en, belief_en, out_valid};
    endfunction

    localparam logic [31:0] C_IDLE   = 32'b1000000;
    localparam logic [31:0] C_LOAD   = 32'b0110000;
    localparam logic [31:0] C_V2C    = 32'b0101000;
    localparam logic [31:0] C_C2V    = 32'b0100100;
    localparam logic [31:0] C_BELIEF = 32'b0100010;
    localparam logic [31:0] C_CHECK  = 32'b0100000;
    localparam logic [31:0] C_DONE   = 32'b0100001;

    task automatic check_all(input string name, input int t, input logic [31:0] ec,
                             input int eit, input int ecv);
        chk($sformatf("%s ctrl t=%0d", name, t), ctrl_obs(), ec);
        chk($sformatf("%s iter t=%0d", name, t), 32'(iter), 32'(eit));
        chk($sformatf("%s conv t=%0d", name, t), 32'(conv), 32'(ecv));
    endtask

    // m: max_iter, ok: first iteration whose CHECK sees syndrome_ok (0 = never),
    // a: abort cycle (0 = none), r: reset cycle (0 = none), rd: out_ready delay.
    // On entry the DUT is idle and the current cycle has been sampled.
    task automatic run(input string name, input int m, input int ok, input int a,
                       input int r, input int rd);
        int lim, k, cv, d, endc, eit, ecv;
        logic [31:0] ec;
        lim = (m == 0) ? 1 : m;
        if (ok >= 1 && ok <= lim) begin k = ok;  cv = 1; end
        else                      begin k = lim; cv = 0; end
        d = 4 * k + 2;                       // first out_valid cycle
        if (r > 0)      endc = r + 1;
        else if (a > 0) endc = a + 1;
        else            endc = d + rd + 1;   // first idle cycle afterwards

        mi = W'(m); start = 1'b1; abort = 1'b0; rst_n = 1'b1; syn = 1'b0;
        @(posedge clk); #1;                  // acceptance edge = cycle 0
        mi = W'($urandom);
        eit = 0; ecv = 0;
        for (int t = 1; t <= endc; t++) begin
            if (t == endc) begin
                ec = C_IDLE;
                if (r > 0)      begin eit = 0;           ecv = 0;  end
                else if (a > 0) begin eit = (a - 1) / 4; ecv = 0;  end
                else            begin eit = k;           ecv = cv; end
            end else if (t == 1) begin
                ec = C_LOAD; eit = 0; ecv = 0;
            end else if (t < d) begin
                case ((t - 2) % 4)
                    0:       ec = C_V2C;
                    1:       ec = C_C2V;
                    2:       ec = C_BELIEF;
                    default: ec = C_CHECK;
                endcase
                eit = (t - 1) / 4; ecv = 0;
            end else begin
                ec = C_DONE; eit = k; ecv = cv;
            end
            check_all(name, t, ec, eit, ecv);
            if (t == endc) break;

            start = 1'($urandom);
            rst_n = (t != r);
            if (t >= 5 && t < d && ((t - 1) % 4) == 0)
                syn = (t == a) || (ok > 0 && ((t - 1) / 4) >= ok);
            else
                syn = 1'($urandom);
            abort = (t == a) || (t >= d && 1'($urandom));
            ordy  = (t >= d) ? (t >= d + rd) : 1'($urandom);
            @(posedge clk); #1;
        end
        // Abort while idle must be ignored.
        start = 1'b0; abort = 1'b1; rst_n = 1'b1; ordy = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        check_all({name, " idle-abort"}, 0, C_IDLE, eit, ecv);
    endtask

    initial begin
        int m, lim, ok, k, d, rd, a, r, sel;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, C_IDLE, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("conv1",    4, 1, 0, 0, 0);
        run("conv3",    5, 3, 0, 0, 0);
        run("limit3",   3, 0, 0, 0, 0);
        run("max0",     0, 0, 0, 0, 0);
        run("hold",     2, 1, 0, 0, 5);
        run("abort7",   4, 0, 7, 0, 0);
        run("abortchk", 4, 0, 9, 0, 0);
        run("reset9",   4, 0, 0, 9, 0);
        run("after",    2, 2, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            m   = $urandom_range(0, 15);
            lim = (m == 0) ? 1 : m;
            ok  = $urandom_range(0, lim + 1);
            k   = (ok >= 1 && ok <= lim) ? ok : lim;
            d   = 4 * k + 2;
            rd  = $urandom_range(0, 3);
            sel = $urandom_range(0, 7);
            a = 0; r = 0;
            if (sel == 0)     r = $urandom_range(1, d + rd);
            else if (sel < 3) a = $urandom_range(1, d - 1);
            run($sformatf("rnd%0d", i), m, ok, a, r, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
